fpga_config_sequencer: RTL and testbench
========================================

FPGA_CONFIG_SEQUENCER -- requirements
Module: fpga_config_sequencer

Interface
REQ-001 Parameter PROG_PULSE_CYC, default 64; cycles fpga_program_b is held low.
REQ-002 Parameter INIT_TIMEOUT_CYC, default 65535; max cycles waited for each fpga_init_b edge.
REQ-003 Parameter DONE_TIMEOUT_CYC, default 65535; max cycles waited for fpga_done after the last byte.
REQ-004 Parameter FLUSH_BYTES, default 2; 0xFF bytes sent after fpga_done rises.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse; begins a configuration; honoured only in IDLE, SUCCESS or FAIL.
REQ-008 abort  in  1  level; forces FAIL from any active state.
REQ-009 src_valid / src_data[7:0] / src_last  in  1/8/1  bitstream byte source; src_last marks the final byte.
REQ-010 src_ready  out  1  byte accepted when src_valid && src_ready on the same edge.
REQ-011 ser_load  out  1  one-cycle pulse; ser_data is valid on that cycle.
REQ-012 ser_data  out  8  byte to serializer, MSB first downstream.
REQ-013 ser_busy  in  1  serializer shifting; high from the cycle after ser_load until the byte is done.
REQ-014 fpga_program_b  out  1  active-low FPGA config reset.
REQ-015 fpga_init_b / fpga_done  in  1/1  FPGA status; two-flop synchronised internally.
REQ-016 busy / cfg_ok / cfg_err  out  1/1/1  status flags.
REQ-017 err_code  out  3  0 none, 1 init-low timeout, 2 init-high timeout, 3 init_b low while streaming, 4 done timeout, 5 abort.

Function
REQ-018 States: IDLE, PROG_LOW, WAIT_INIT_LOW, WAIT_INIT_HIGH, STREAM, WAIT_DONE, FLUSH, SUCCESS, FAIL.
REQ-019 IDLE/SUCCESS/FAIL + start -> PROG_LOW; clears cfg_ok, cfg_err, err_code and the timeout counter.
REQ-020 PROG_LOW: fpga_program_b=0 for exactly PROG_PULSE_CYC cycles, then WAIT_INIT_LOW.
REQ-021 WAIT_INIT_LOW: synced init_b=0 -> WAIT_INIT_HIGH; counter reaches INIT_TIMEOUT_CYC -> FAIL with code 1.
REQ-022 WAIT_INIT_HIGH: synced init_b=1 -> STREAM; timeout -> FAIL with code 2.
REQ-023 Timeout counter is 16 bits; it resets on every state entry and saturates, with no wrap.
REQ-024 STREAM: src_ready = !ser_busy && !ser_load && !last_taken; an accepted byte drives ser_load=1 and ser_data=src_data on the next cycle.
REQ-025 STREAM: after the src_last byte is accepted and ser_busy falls -> WAIT_DONE.
REQ-026 STREAM/WAIT_DONE: synced init_b=0 -> FAIL with code 3; this takes priority over byte acceptance in the same cycle.
REQ-027 WAIT_DONE: synced done=1 -> FLUSH; timeout on DONE_TIMEOUT_CYC -> FAIL with code 4.
REQ-028 FLUSH: issue FLUSH_BYTES loads of 0xFF with the REQ-024 spacing; after the last one and ser_busy low -> SUCCESS. If FLUSH_BYTES=0 -> SUCCESS directly.
REQ-029 SUCCESS: cfg_ok=1; FAIL: cfg_err=1; both hold until the next start.
REQ-030 busy=1 in every state except IDLE, SUCCESS and FAIL; src_ready=0 outside STREAM.
REQ-031 abort in any busy state -> FAIL with code 5 next cycle; abort outranks every other transition; abort in IDLE/SUCCESS/FAIL is ignored.
REQ-032 fpga_program_b=1 in all states except PROG_LOW.
REQ-033 start while busy is ignored.

Reset
REQ-034 rst_n low -> asynchronously enter IDLE with fpga_program_b=1, src_ready=0, ser_load=0, ser_data=0, busy=0, cfg_ok=0, cfg_err=0, err_code=0, counters=0, sync flops=0.
REQ-035 Reset mid-stream abandons the configuration silently, and any partially loaded byte is dropped.

Configuration
REQ-036 Macro CFG_BYTE_COUNT_EN defined: 24-bit output byte_count counts accepted src bytes, excluding flush bytes; it is cleared on start, saturates at 0xFFFFFF, and holds its value in SUCCESS/FAIL.
REQ-037 Macro CFG_BYTE_COUNT_EN undefined: byte_count port is present and tied to 0, and no counter logic is generated.

Verification
REQ-038 Nominal: start; init_b falls at cycle 10 and rises 20 cycles later; 4 bytes A5,3C,FF,00 with last on 00; done rises 50 cycles later -> 6 ser_load pulses with data A5,3C,FF,00,FF,FF; cfg_ok=1; err_code=0; byte_count=4.
REQ-039 init_b stuck high with INIT_TIMEOUT_CYC=100 -> FAIL and err_code=1 within 100+PROG_PULSE_CYC+3 cycles.
REQ-040 init_b pulled low after byte 2 of 4 -> FAIL, err_code=3, src_ready=0 from the next cycle, no further ser_load.
REQ-041 done never rises with DONE_TIMEOUT_CYC=200 -> err_code=4 and cfg_err=1.
REQ-042 abort asserted during PROG_LOW -> err_code=5 and fpga_program_b=1 the next cycle; a subsequent start restarts cleanly with all flags cleared.
REQ-043 rst_n pulsed low mid-STREAM with ser_busy=1 -> IDLE immediately with all REQ-034 values, and no ser_load after release.

Source files
------------

// File: rtl/fpga_config_sequencer.sv
// FPGA slave-serial configuration sequencer.
// Pulses PROGRAM_B, waits for the INIT_B handshake, streams bitstream bytes to an
// external serializer, waits for DONE and then clocks out flush bytes.
// Optional feature macro: CFG_BYTE_COUNT_EN (adds a live accepted-byte counter).
module fpga_config_sequencer #(
    parameter int unsigned PROG_PULSE_CYC   = 64,
    parameter int unsigned INIT_TIMEOUT_CYC = 65535,
    parameter int unsigned DONE_TIMEOUT_CYC = 65535,
    parameter int unsigned FLUSH_BYTES      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        src_valid,
    input  logic [7:0]  src_data,
    input  logic        src_last,
    output logic        src_ready,
    output logic        ser_load,
    output logic [7:0]  ser_data,
    input  logic        ser_busy,
    output logic        fpga_program_b,
    input  logic        fpga_init_b,
    input  logic        fpga_done,
    output logic        busy,
    output logic        cfg_ok,
    output logic        cfg_err,
    output logic [2:0]  err_code,
    output logic [23:0] byte_count
);

    typedef enum logic [3:0] {
        StIdle,
        StProgLow,
        StWaitInitLow,
        StWaitInitHigh,
        StStream,
        StWaitDone,
        StFlush,
        StSuccess,
        StFail
    } state_e;

    localparam logic [2:0] ErrNone     = 3'd0;
    localparam logic [2:0] ErrInitLow  = 3'd1;
    localparam logic [2:0] ErrInitHigh = 3'd2;
    localparam logic [2:0] ErrInitLost = 3'd3;
    localparam logic [2:0] ErrDone     = 3'd4;
    localparam logic [2:0] ErrAbort    = 3'd5;

    localparam logic [16:0] ProgLim  = 17'(PROG_PULSE_CYC);
    localparam logic [16:0] InitLim  = 17'(INIT_TIMEOUT_CYC);
    localparam logic [16:0] DoneLim  = 17'(DONE_TIMEOUT_CYC);
    localparam logic [15:0] FlushLim = 16'(FLUSH_BYTES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] flush_q, flush_d;
    logic        last_q, last_d;
    logic        load_q, load_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  err_q, err_d;
    logic [1:0]  init_sync_q, done_sync_q;

    logic        init_s, done_s;
    logic        slot_free;
    logic [16:0] cnt_inc;

    assign init_s    = init_sync_q[1];
    assign done_s    = done_sync_q[1];
    // Serializer can take a byte only when idle and no load is already in flight.
    assign slot_free = !ser_busy && !load_q;
    assign cnt_inc   = {1'b0, cnt_q} + 17'd1;

    assign busy           = !(state_q inside {StIdle, StSuccess, StFail});
    assign cfg_ok         = (state_q == StSuccess);
    assign cfg_err        = (state_q == StFail);
    assign fpga_program_b = (state_q != StProgLow);
    assign err_code       = err_q;
    assign ser_load       = load_q;
    assign ser_data       = data_q;

    // Two-flop synchronisers for the asynchronous FPGA status pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_sync_q <= 2'b00;
            done_sync_q <= 2'b00;
        end else begin
            init_sync_q <= {init_sync_q[0], fpga_init_b};
            done_sync_q <= {done_sync_q[0], fpga_done};
        end
    end

    // Byte acceptance; a lost INIT_B or an abort blocks it in the same cycle.
    always_comb begin
        src_ready = (state_q == StStream) && slot_free && !last_q && init_s && !abort;
    end

    // Next-state logic and datapath updates.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        last_d  = last_q;
        flush_d = flush_q;
        load_d  = 1'b0;
        data_d  = data_q;

        unique case (state_q)
            StIdle, StSuccess, StFail: begin
                if (start) begin
                    state_d = StProgLow;
                    err_d   = ErrNone;
                    last_d  = 1'b0;
                    flush_d = '0;
                end
            end
            StProgLow: begin
                if (cnt_inc >= ProgLim) state_d = StWaitInitLow;
            end
            StWaitInitLow: begin
                if (!init_s) begin
                    state_d = StWaitInitHigh;
                end else if (cnt_inc >= InitLim) begin
                    state_d = StFail;
                    err_d   = ErrInitLow;
                end
            end
            StWaitInitHigh: begin
                if (init_s) begin
                    state_d = StStream;
                end else if (cnt_inc >= InitLim) begin
                    state_d = StFail;
                    err_d   = ErrInitHigh;
                end
            end
            StStream: begin
                if (!init_s) begin
                    state_d = StFail;
                    err_d   = ErrInitLost;
                end else begin
                    if (src_valid && src_ready) begin
                        load_d = 1'b1;
                        data_d = src_data;
                        if (src_last) last_d = 1'b1;
                    end
                    if (last_q && slot_free) state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!init_s) begin
                    state_d = StFail;
                    err_d   = ErrInitLost;
                end else if (done_s) begin
                    state_d = (FlushLim == 16'd0) ? StSuccess : StFlush;
                end else if (cnt_inc >= DoneLim) begin
                    state_d = StFail;
                    err_d   = ErrDone;
                end
            end
            StFlush: begin
                if (slot_free) begin
                    if (flush_q < FlushLim) begin
                        load_d  = 1'b1;
                        data_d  = 8'hFF;
                        flush_d = flush_q + 16'd1;
                    end else begin
                        state_d = StSuccess;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort outranks everything while a configuration is active.
        if (busy && abort) begin
            state_d = StFail;
            err_d   = ErrAbort;
            load_d  = 1'b0;
            data_d  = data_q;
        end
    end

    // Per-state timeout counter: cleared on entry, saturating.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == 16'hFFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            flush_q <= '0;
            last_q  <= 1'b0;
            load_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= ErrNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            last_q  <= last_d;
            load_q  <= load_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef CFG_BYTE_COUNT_EN
    logic [23:0] bc_q;
    logic        bc_clr, bc_inc;

    assign bc_clr     = (state_q inside {StIdle, StSuccess, StFail}) && (state_d == StProgLow);
    assign bc_inc     = (state_q == StStream) && src_valid && src_ready && (state_d != StFail);
    assign byte_count = bc_q;

    // Accepted source byte counter, saturating; flush bytes are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_q <= '0;
        end else if (bc_clr) begin
            bc_q <= '0;
        end else if (bc_inc && (bc_q != 24'hFFFFFF)) begin
            bc_q <= bc_q + 24'd1;
        end
    end
`else
    assign byte_count = '0;
`endif

endmodule

// File: tb/tb_fpga_config_sequencer.sv
// Self-checking bench for fpga_config_sequencer: random bitstreams, an FPGA pin
// model, a serializer busy model and a scoreboard of expected ser_data bytes.
module tb_fpga_config_sequencer;

    localparam int PP = 16;
    localparam int IT = 100;
    localparam int DT = 200;
    localparam int FB = 2;
`ifdef CFG_BYTE_COUNT_EN
    localparam bit BcEn = 1'b1;
`else
    localparam bit BcEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        src_valid = 1'b0;
    logic [7:0]  src_data = 8'h00;
    logic        src_last = 1'b0;
    logic        src_ready;
    logic        ser_load;
    logic [7:0]  ser_data;
    logic        ser_busy;
    logic        fpga_program_b;
    logic        fpga_init_b = 1'b1;
    logic        fpga_done = 1'b0;
    logic        busy, cfg_ok, cfg_err;
    logic [2:0]  err_code;
    logic [23:0] byte_count;

    fpga_config_sequencer #(
        .PROG_PULSE_CYC  (PP),
        .INIT_TIMEOUT_CYC(IT),
        .DONE_TIMEOUT_CYC(DT),
        .FLUSH_BYTES     (FB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_last      (src_last),
        .src_ready     (src_ready),
        .ser_load      (ser_load),
        .ser_data      (ser_data),
        .ser_busy      (ser_busy),
        .fpga_program_b(fpga_program_b),
        .fpga_init_b   (fpga_init_b),
        .fpga_done     (fpga_done),
        .busy          (busy),
        .cfg_ok        (cfg_ok),
        .cfg_err       (cfg_err),
        .err_code      (err_code),
        .byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    // Serializer model: busy for ser_len cycles starting the cycle after a load.
    int ser_len = 3;
    int busy_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 0;
        else if (ser_load) busy_cnt <= ser_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign ser_busy = (busy_cnt != 0);

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] bytes[16];

    function automatic logic [23:0] exp_bc(input int n);
        return BcEn ? 24'(n) : 24'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ser_load pops one expected byte.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && ser_load) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_load: got %0h expected no load", ser_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("ser_data", 32'(ser_data), 32'(e));
                end
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_program_b"}, 32'(fpga_program_b), 1);
        chk({tag, "_src_ready"}, 32'(src_ready), 0);
        chk({tag, "_ser_load"}, 32'(ser_load), 0);
        chk({tag, "_ser_data"}, 32'(ser_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cfg_ok"}, 32'(cfg_ok), 0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
        chk({tag, "_err_code"}, 32'(err_code), 0);
        chk({tag, "_byte_count"}, 32'(byte_count), 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        bit hs;
        src_valid = 1'b0;
        tick($urandom_range(0, 2));
        src_valid = 1'b1;
        src_data  = d;
        src_last  = last;
        hs = 1'b0;
        for (int g = 0; g < 2000; g++) begin
            if (src_ready) hs = 1'b1;
            tick();
            if (hs) break;
        end
        src_valid = 1'b0;
        src_last  = 1'b0;
        if (!hs) begin
            total++;
            bad++;
            $display("FAIL src_handshake: got no src_ready expected acceptance of %0h", d);
        end
    endtask

    task automatic wait_end(input int limit, output int n);
        n = 0;
        while (!(cfg_ok || cfg_err) && n < limit) begin
            tick();
            n++;
        end
        chk("end_reached", 32'(cfg_ok | cfg_err), 1);
    endtask

    task automatic init_seq(input int d1, input int d2);
        tick(d1);
        fpga_init_b = 1'b0;
        tick(d2);
        fpga_init_b = 1'b1;
    endtask

    // Full successful configuration: stream bytes[0..n-1], then done, then flush.
    task automatic run_success(input int n, input int d1, input int d2, input int d3,
                               input bit poke_start);
        int w;
        for (int i = 0; i < n; i++) exp_q.push_back(bytes[i]);
        for (int i = 0; i < FB; i++) exp_q.push_back(8'hFF);
        pulse_start();
        chk("start_clears_ok", 32'(cfg_ok), 0);
        chk("start_clears_err", 32'(cfg_err), 0);
        chk("start_clears_code", 32'(err_code), 0);
        chk("start_busy", 32'(busy), 1);
        init_seq(d1, d2);
        if (poke_start) begin
            tick(4);
            pulse_start();
            chk("start_ignored_busy", 32'(busy), 1);
            chk("start_ignored_progb", 32'(fpga_program_b), 1);
        end
        for (int i = 0; i < n; i++) send_byte(bytes[i], i == n - 1);
        tick(d3);
        fpga_done = 1'b1;
        wait_end(3000, w);
        chk("ok_cfg_ok", 32'(cfg_ok), 1);
        chk("ok_cfg_err", 32'(cfg_err), 0);
        chk("ok_err_code", 32'(err_code), 0);
        chk("ok_busy", 32'(busy), 0);
        chk("ok_program_b", 32'(fpga_program_b), 1);
        chk("ok_byte_count", 32'(byte_count), 32'(exp_bc(n)));
        tick(2);
        chk("ok_sb_empty", 32'(exp_q.size()), 0);
        fpga_done = 1'b0;
        tick(3);
    endtask

    initial begin
        int w;
        int rc;
        fork
            monitor();
        join_none

        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // Nominal stream with a start pulse while busy.
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h00;
        run_success(4, 10, 20, 50, 1'b1);

        // Randomised successful configurations.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 12);
            ser_len = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
            run_success(n, $urandom_range(1, 30), $urandom_range(1, 60),
                        $urandom_range(0, 80), 1'b0);
        end
        ser_len = 3;

        // INIT_B never falls.
        pulse_start();
        w = 0;
        while (!cfg_err && w < PP + IT + 10) begin
            tick();
            w++;
        end
        chk("init_lo_code", 32'(err_code), 1);
        chk("init_lo_cfg_err", 32'(cfg_err), 1);
        chk("init_lo_latency_ok", 32'(w >= IT && w <= PP + IT + 3), 1);
        tick(2);

        // INIT_B falls but never returns high.
        pulse_start();
        tick(5);
        fpga_init_b = 1'b0;
        wait_end(PP + IT + 50, w);
        chk("init_hi_code", 32'(err_code), 2);
        fpga_init_b = 1'b1;
        tick(3);

        // INIT_B lost after byte 2 of 4.
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        pulse_start();
        init_seq(5, 10);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        tick(12);
        fpga_init_b = 1'b0;
        tick(4);
        chk("lost_cfg_err", 32'(cfg_err), 1);
        chk("lost_code", 32'(err_code), 3);
        chk("lost_src_ready", 32'(src_ready), 0);
        src_valid = 1'b1;
        src_data  = 8'h33;
        rc = 0;
        repeat (10) begin
            if (src_ready) rc++;
            tick();
        end
        chk("lost_ready_cycles", 32'(rc), 0);
        chk("lost_byte_count", 32'(byte_count), 32'(exp_bc(2)));
        chk("lost_sb_empty", 32'(exp_q.size()), 0);
        src_valid = 1'b0;
        fpga_init_b = 1'b1;
        tick(3);

        // DONE never rises.
        for (int i = 0; i < 3; i++) begin
            bytes[i] = 8'($urandom);
            exp_q.push_back(bytes[i]);
        end
        pulse_start();
        init_seq(5, 10);
        for (int i = 0; i < 3; i++) send_byte(bytes[i], i == 2);
        wait_end(DT + 100, w);
        chk("done_to_code", 32'(err_code), 4);
        chk("done_to_cfg_err", 32'(cfg_err), 1);
        chk("done_to_cfg_ok", 32'(cfg_ok), 0);
        chk("done_to_byte_count", 32'(byte_count), 32'(exp_bc(3)));
        chk("done_to_sb_empty", 32'(exp_q.size()), 0);
        tick(3);

        // Abort during PROGRAM_B pulse, then a clean restart.
        pulse_start();
        tick(3);
        chk("prog_low_progb", 32'(fpga_program_b), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_cfg_err", 32'(cfg_err), 1);
        chk("abort_code", 32'(err_code), 5);
        chk("abort_progb", 32'(fpga_program_b), 1);
        chk("abort_busy", 32'(busy), 0);
        abort = 1'b1;
        tick(2);
        abort = 1'b0;
        chk("abort_idle_ignored", 32'(err_code), 5);
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h00;
        run_success(4, 10, 20, 50, 1'b0);

        // Reset while the serializer is busy mid-stream.
        ser_len = 8;
        exp_q.push_back(8'h5A);
        pulse_start();
        init_seq(5, 10);
        send_byte(8'h5A, 1'b0);
        w = 0;
        while (!ser_busy && w < 20) begin
            tick();
            w++;
        end
        chk("rst_mid_ser_busy", 32'(ser_busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("rst_mid_idle_busy", 32'(busy), 0);
        chk("rst_mid_sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
